// File: rtl/alarm_control.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alarm_control
// Sequences the alarm of the digital clock. A rising edge of the time match
// (clock hh:mm equal to alarm hh:mm) while the alarm is armed starts ringing.
// Ringing can be stopped, snoozed a bounded number of times, or times out on
// its own. All durations are counted in tick_1hz pulses.
//
// Ports:
//   ck        in   system clock
//   reset_n   in   asynchronous active-low reset
//   tick_1hz  in   one-ck pulse per second
//   alarm_en  in   alarm armed (level)
//   clk_hh    in   current hours   (0..23)
//   clk_mm    in   current minutes (0..59)
//   al_hh     in   alarm hours     (0..23)
//   al_mm     in   alarm minutes   (0..59)
//   stop      in   stop button level, synchronous to ck
//   snooze    in   snooze button level, synchronous to ck
//   buzzer    out  buzzer drive (registered)
//   ringing   out  high while in RING
//   snoozing  out  high while in SNOOZE
// -----------------------------------------------------------------------------
module alarm_control #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int CNT_W       = 9
) (
    input  logic       ck,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic [4:0] clk_hh,
    input  logic [5:0] clk_mm,
    input  logic [4:0] al_hh,
    input  logic [5:0] al_mm,
    input  logic       stop,
    input  logic       snooze,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing
);

    localparam int SNZ_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
    localparam logic [SNZ_W-1:0] SNZ_MAX     = SNZ_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SNZ_W-1:0] snz_reg, snz_next;
    logic             buzzer_reg, buzzer_next;
    logic             match_q, stop_q, snooze_q;

    logic match, trigger, stop_p, snooze_p;

    assign match    = (clk_hh == al_hh) && (clk_mm == al_mm);
    // Only a fresh match fires; match_q resets high so a match already
    // present when reset releases does not ring.
    assign trigger  = match && !match_q && alarm_en;
    assign stop_p   = stop && !stop_q;
    assign snooze_p = snooze && !snooze_q;

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            snz_reg    <= '0;
            buzzer_reg <= 1'b0;
            match_q    <= 1'b1;
            stop_q     <= 1'b0;
            snooze_q   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            snz_reg    <= snz_next;
            buzzer_reg <= buzzer_next;
            match_q    <= match;
            stop_q     <= stop;
            snooze_q   <= snooze;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        snz_next    = snz_reg;
        buzzer_next = buzzer_reg;

        unique case (state_reg)
            IDLE: begin
                buzzer_next = 1'b0;
                if (trigger) begin
                    state_next  = RING;
                    cnt_next    = '0;
                    snz_next    = '0;
                    buzzer_next = 1'b1;
                end
            end

            RING: begin
                if (!alarm_en || stop_p) begin
                    state_next  = IDLE;
                    buzzer_next = 1'b0;
                end else if (snooze_p && (snz_reg < SNZ_MAX)) begin
                    state_next  = SNOOZE;
                    cnt_next    = '0;
                    snz_next    = snz_reg + 1'b1;
                    buzzer_next = 1'b0;
                end else if (tick_1hz) begin
                    // A snooze press past the limit lands here and is ignored.
                    if (cnt_reg == RING_LAST) begin
                        state_next  = IDLE;
                        buzzer_next = 1'b0;
                    end else begin
                        cnt_next    = cnt_reg + 1'b1;
                        buzzer_next = !buzzer_reg;
                    end
                end
            end

            SNOOZE: begin
                buzzer_next = 1'b0;
                if (!alarm_en || stop_p) begin
                    state_next = IDLE;
                end else if (tick_1hz) begin
                    if (cnt_reg == SNOOZE_LAST) begin
                        state_next  = RING;
                        cnt_next    = '0;
                        buzzer_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next  = IDLE;
                buzzer_next = 1'b0;
            end
        endcase
    end

    assign buzzer   = buzzer_reg;
    assign ringing  = (state_reg == RING);
    assign snoozing = (state_reg == SNOOZE);

endmodule
